// File: rtl/encode_20_pkg.sv
// encode_20_pkg: shared types and 2-of-5 code constants for the BCD encoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package encode_20_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [4:0] code_t;

  // 2-of-5 code words, bit weights 7-4-2-1-0 from MSB to LSB.
  // Zero has no natural pair in this weighting, so it reuses 7+4 (=11).
  localparam code_t CODE_0       = 5'b11000;
  localparam code_t CODE_1       = 5'b00011;
  localparam code_t CODE_2       = 5'b00101;
  localparam code_t CODE_3       = 5'b00110;
  localparam code_t CODE_4       = 5'b01001;
  localparam code_t CODE_5       = 5'b01010;
  localparam code_t CODE_6       = 5'b01100;
  localparam code_t CODE_7       = 5'b10001;
  localparam code_t CODE_8       = 5'b10010;
  localparam code_t CODE_9       = 5'b10100;
  localparam code_t CODE_ILLEGAL = 5'b00000;

endpackage

// File: rtl/encode_digit.sv
// encode_digit: combinational BCD digit to 2-of-5 code converter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
// Ports: digit (4b BCD in), code (5b 2-of-5 out), err (1 = digit above 9).
module encode_digit
  import encode_20_pkg::*;
(
  input  logic [3:0] digit,
  output logic [4:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ILLEGAL;
    err  = 1'b0;
    case (digit)
      4'd0:    code = CODE_0;
      4'd1:    code = CODE_1;
      4'd2:    code = CODE_2;
      4'd3:    code = CODE_3;
      4'd4:    code = CODE_4;
      4'd5:    code = CODE_5;
      4'd6:    code = CODE_6;
      4'd7:    code = CODE_7;
      4'd8:    code = CODE_8;
      4'd9:    code = CODE_9;
      default: begin
        // 10-15 are not BCD: emit the all-zero word and flag it
        code = CODE_ILLEGAL;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/encode_20.sv
// encode_20: registers the 2-of-5 encoding of four BCD digits.
// Latency: 1 cycle from in_valid edge to out_valid.
// Backpressure: none; accepts a new set every cycle, outputs hold when idle.
// Ports: clk, rst_n (sync, active-low), in_valid + in1..in4 (BCD, in1 MSD),
//        out1..out4 (5b codes), total ({out1..out4}), out_valid, err[3:0].
module encode_20
  import encode_20_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in1,
  input  logic [3:0]  in2,
  input  logic [3:0]  in3,
  input  logic [3:0]  in4,
  output logic [4:0]  out1,
  output logic [4:0]  out2,
  output logic [4:0]  out3,
  output logic [4:0]  out4,
  output logic [19:0] total,
  output logic        out_valid,
  output logic [3:0]  err
);

  code_t      c1, c2, c3, c4;
  logic [3:0] e;

  encode_digit u_d1 (.digit(in1), .code(c1), .err(e[3]));
  encode_digit u_d2 (.digit(in2), .code(c2), .err(e[2]));
  encode_digit u_d3 (.digit(in3), .code(c3), .err(e[1]));
  encode_digit u_d4 (.digit(in4), .code(c4), .err(e[0]));

  // Reset wins over a coincident in_valid, so that cycle's data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out1      <= CODE_ILLEGAL;
      out2      <= CODE_ILLEGAL;
      out3      <= CODE_ILLEGAL;
      out4      <= CODE_ILLEGAL;
      err       <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out1 <= c1;
        out2 <= c2;
        out3 <= c3;
        out4 <= c4;
        err  <= e;
      end
    end
  end

  // Derived from the registers so it can never disagree with out1..out4.
  assign total = {out1, out2, out3, out4};

endmodule

// File: tb/tb_encode_20.sv
module tb_encode_20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [4:0]  out1, out2, out3, out4;
  logic [19:0] total;
  logic        out_valid;
  logic [3:0]  err;

  encode_20 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .total(total), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] total;
    logic [3:0]  err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  logic [19:0] held_t = '0;
  logic [3:0]  held_e = '0;

  // Reference: find the pair of weights (7,4,2,1,0) summing to the digit;
  // zero is represented by 7+4. Illegal digits give an all-zero word.
  function automatic logic [4:0] ref_code(input int d);
    int w[5];
    int target;
    logic [4:0] c;
    w[0] = 7; w[1] = 4; w[2] = 2; w[3] = 1; w[4] = 0;
    c = 5'b00000;
    if (d > 9) return c;
    target = (d == 0) ? 11 : d;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (w[i] + w[j] == target) begin
          c[4-i] = 1'b1;
          c[4-j] = 1'b1;
        end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected result is queued only when the
  // edge will actually accept the data (valid and not in reset).
  task automatic drive(input logic v, input int a, input int b, input int c,
                       input int d, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rn;
    in_valid = v;
    in1 = 4'(a); in2 = 4'(b); in3 = 4'(c); in4 = 4'(d);
    if (v && rn) begin
      e.total = {ref_code(a), ref_code(b), ref_code(c), ref_code(d)};
      e.err   = {a > 9, b > 9, c > 9, d > 9};
      e.due   = cyc + 1;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst_n;
  end

  // Monitor: compares every cycle against the scoreboard head or held state.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid_high", 32'(out_valid), 32'd1);
      held_t = e.total;
      held_e = e.err;
      for (int k = 0; k < 4; k++)
        if (!e.err[3-k])
          chk("popcount", $countones(total[19-5*k -: 5]), 32'd2);
    end else begin
      chk("out_valid_low", 32'(out_valid), 32'd0);
      if (!rst_seen) begin
        held_t = '0;
        held_e = '0;
      end
    end
    chk("total", 32'(total), 32'(held_t));
    chk("err",   32'(err),   32'(held_e));
    chk("out1",  32'(out1),  32'(held_t[19:15]));
    chk("out2",  32'(out2),  32'(held_t[14:10]));
    chk("out3",  32'(out3),  32'(held_t[9:5]));
    chk("out4",  32'(out4),  32'(held_t[4:0]));
  end

  initial begin
    // reset held for 10 cycles, with junk valid data that must be ignored
    for (int i = 0; i < 10; i++) drive(1'b1, 5, 5, 5, 5, 1'b0);
    // zeros, mixed back-to-back, hold on idle
    drive(1'b1, 0, 0, 0, 0, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    drive(1'b1, 1, 4, 3, 2, 1'b1);
    drive(1'b1, 9, 8, 7, 6, 1'b1);
    drive(1'b1, 2, 2, 5, 7, 1'b1);
    drive(1'b0, 9, 9, 9, 9, 1'b1);
    drive(1'b0, 1, 3, 8, 0, 1'b1);
    // illegal digits
    drive(1'b1, 12, 3, 15, 9, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    // mid-stream reset with valid data, then immediate restart
    drive(1'b1, 3, 3, 3, 3, 1'b1);
    drive(1'b1, 7, 7, 7, 7, 1'b0);
    drive(1'b1, 4, 5, 6, 8, 1'b1);
    // every value on every position
    for (int v = 0; v < 16; v++)
      drive(1'b1, v, (v + 1) % 16, (v + 5) % 16, (v + 11) % 16, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 9) < 7,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            $urandom_range(0, 49) != 0);
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
